// File: rtl/crc5_frame_tx_pkg.sv
// Shared types and constants for the CRC-5 transmit framer and its companion engine.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package crc5_frame_tx_pkg;

    localparam logic [7:0] SOF_BYTE_DEFAULT = 8'hA5;
    localparam logic [4:0] CRC5_INIT        = 5'h1F;
    localparam logic [4:0] CRC5_POLY        = 5'h05;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SOF      = 3'd1,
        ST_PAYLOAD  = 3'd2,
        ST_CRC_WAIT = 3'd3,
        ST_TRAILER  = 3'd4
    } state_e;

    // One byte of CRC-5 (x^5+x^2+1), MSB first, no reflection, no final xor.
    function automatic logic [4:0] crc5_next(input logic [4:0] crc, input logic [7:0] data);
        logic [4:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            if (c[4] ^ data[i]) begin
                c = {c[3:0], 1'b0} ^ CRC5_POLY;
            end else begin
                c = {c[3:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/crc5_frame_tx_if.sv
// Byte stream with valid/ready handshake and end-of-frame marker.
// Latency: n/a (wires only).
// Backpressure: a byte moves on a cycle where valid and ready are both high.
interface crc5_frame_tx_if;
    logic       valid;
    logic [7:0] data;
    logic       last;
    logic       ready;

    modport master (output valid, output data, output last, input  ready);
    modport slave  (input  valid, input  data, input  last, output ready);
endinterface

// File: rtl/crc5_frame_tx_crc.sv
// Byte-wide CRC-5 engine: synchronous clear to 5'h1F, one byte folded in per enable.
// Latency: result visible the cycle after the enable strobe.
// Backpressure: none; the caller strobes en only for bytes it wants included.
module crc5_frame_tx_crc
    import crc5_frame_tx_pkg::*;
(
    input  logic       ck,
    input  logic       rst,
    input  logic       crc_clr,
    input  logic       crc_en,
    input  logic [7:0] crc_data,
    output logic [4:0] crc_value
);

    logic [4:0] crc_q, crc_d;

    // Clear has priority over update so a framer in IDLE always restarts from init.
    always_comb begin
        crc_d = crc_q;
        if (crc_clr) begin
            crc_d = CRC5_INIT;
        end else if (crc_en) begin
            crc_d = crc5_next(crc_q, crc_data);
        end
    end

    // CRC register with synchronous reset to the init value.
    always_ff @(posedge ck) begin
        if (rst) begin
            crc_q <= CRC5_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_value = crc_q;

endmodule

// File: rtl/crc5_frame_tx.sv
// Frames payload as SOF byte, payload bytes, CRC-5 trailer byte; drives the CRC engine.
// Latency: SOF one cycle after in_valid in IDLE; trailer two cycles after the last payload byte.
// Backpressure: payload is a combinational pass-through (in_ready = out_ready); SOF/trailer hold until out_ready.
module crc5_frame_tx
    import crc5_frame_tx_pkg::*;
#(
    parameter logic [7:0] SOF_BYTE = SOF_BYTE_DEFAULT,
    parameter int         LEN_W    = 8,
    parameter int         CNT_W    = 16
) (
    input  logic              ck,
    input  logic              rst,
    crc5_frame_tx_if.slave    in_if,
    crc5_frame_tx_if.master   out_if,
    output logic [7:0]        crc_data,
    output logic              crc_en,
    output logic              crc_clr,
    input  logic [4:0]        crc_value,
    output logic [LEN_W-1:0]  payload_len,
    output logic [CNT_W-1:0]  frame_count,
    output logic              busy
);

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   payload_len_q, payload_len_d;
    logic [CNT_W-1:0]   frame_count_q, frame_count_d;

    // Next-state, stream outputs and engine strobes, all decoded from the current state.
    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        payload_len_d = payload_len_q;
        frame_count_d = frame_count_q;
        in_if.ready   = 1'b0;
        out_if.valid  = 1'b0;
        out_if.data   = 8'h00;
        out_if.last   = 1'b0;
        crc_data      = 8'h00;
        crc_en        = 1'b0;
        crc_clr       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                crc_clr = 1'b1;
                len_d   = '0;
                // The pending byte is only looked at here, not consumed.
                if (in_if.valid) begin
                    state_d = ST_SOF;
                end
            end
            ST_SOF: begin
                out_if.valid = 1'b1;
                out_if.data  = SOF_BYTE;
                if (out_if.ready) begin
                    state_d = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                out_if.valid = in_if.valid;
                out_if.data  = in_if.data;
                in_if.ready  = out_if.ready;
                crc_data     = in_if.data;
                crc_en       = in_if.valid & out_if.ready;
                if (in_if.valid && out_if.ready) begin
                    len_d = len_q + 1'b1;
                    if (in_if.last) begin
                        state_d = ST_CRC_WAIT;
                    end
                end
            end
            ST_CRC_WAIT: begin
                // Engine registers the final byte during this cycle.
                state_d = ST_TRAILER;
            end
            ST_TRAILER: begin
                out_if.valid = 1'b1;
                out_if.data  = {3'b000, crc_value};
                out_if.last  = 1'b1;
                if (out_if.ready) begin
                    payload_len_d = len_q;
                    frame_count_d = frame_count_q + 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and counters; reset drops any partial frame.
    always_ff @(posedge ck) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            len_q         <= '0;
            payload_len_q <= '0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            payload_len_q <= payload_len_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign payload_len = payload_len_q;
    assign frame_count = frame_count_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_crc5_frame_tx.sv
// Bench for crc5_frame_tx together with its CRC-5 engine: stream scoreboard plus directed cases.
module tb_crc5_frame_tx;
    import crc5_frame_tx_pkg::*;

    logic        ck;
    logic        rst;
    logic [7:0]  crc_data;
    logic        crc_en;
    logic        crc_clr;
    logic [4:0]  crc_value;
    logic [7:0]  payload_len;
    logic [15:0] frame_count;
    logic        busy;

    crc5_frame_tx_if up_if ();
    crc5_frame_tx_if dn_if ();

    crc5_frame_tx #(.SOF_BYTE(8'hA5), .LEN_W(8), .CNT_W(16)) dut (
        .ck          (ck),
        .rst         (rst),
        .in_if       (up_if),
        .out_if      (dn_if),
        .crc_data    (crc_data),
        .crc_en      (crc_en),
        .crc_clr     (crc_clr),
        .crc_value   (crc_value),
        .payload_len (payload_len),
        .frame_count (frame_count),
        .busy        (busy)
    );

    crc5_frame_tx_crc u_crc (
        .ck        (ck),
        .rst       (rst),
        .crc_clr   (crc_clr),
        .crc_en    (crc_en),
        .crc_data  (crc_data),
        .crc_value (crc_value)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    // Upstream must hold a byte it has offered until it is taken.
    assume property (@(posedge ck) disable iff (rst) (up_if.valid && !up_if.ready) |=> up_if.valid);

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference CRC-5: polynomial 0x05, init 0x1F, bits taken MSB first.
    function automatic logic [4:0] model_crc(input logic [7:0] b[$]);
        int r;
        r = 31;
        for (int i = 0; i < b.size(); i++) begin
            for (int k = 7; k >= 0; k--) begin
                int fbk;
                fbk = ((r >> 4) & 1) ^ ((int'(b[i]) >> k) & 1);
                r = ((r << 1) & 31) ^ (fbk != 0 ? 5 : 0);
            end
        end
        return r[4:0];
    endfunction

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic       f;
    } exp_t;

    exp_t        exp_q[$];
    int          elen_q[$];
    exp_t        e;
    logic [7:0]  fb[$];
    logic [7:0]  tq[$];

    // Model state, advanced by the compare process on accepted output bytes.
    int          m_pl, m_fc, en_cnt, last_en_cnt, trk, xfer_idx, exp_frames;
    logic [7:0]  last_trailer;
    bit          clr_seen, prev_vld, prev_rdy, prev_last, prev_idle_req;
    logic [7:0]  prev_dat;
    int          rdy_mode;

    // Single compare process: every cycle, outside reset.
    always @(negedge ck) begin
        if (rst) begin
            exp_q.delete();
            elen_q.delete();
            m_pl = 0; m_fc = 0; en_cnt = 0; trk = 0; xfer_idx = 0;
            clr_seen = 0; prev_vld = 0; prev_rdy = 0; prev_idle_req = 0;
        end else begin
            chk("payload_len", 32'(payload_len), 32'(m_pl));
            chk("frame_count", 32'(frame_count), 32'(m_fc));
            chk("crc_en_vs_xfer", 32'(crc_en), 32'(up_if.valid && up_if.ready));
            chk("crc_clr_vs_idle", 32'(crc_clr), 32'(!busy));
            if (up_if.ready) chk("in_ready_needs_out_ready", 32'(dn_if.ready), 32'd1);
            if (prev_vld && !prev_rdy) begin
                chk("hold_valid", 32'(dn_if.valid), 32'd1);
                chk("hold_data", 32'(dn_if.data), 32'(prev_dat));
                chk("hold_last", 32'(dn_if.last), 32'(prev_last));
            end
            if (prev_idle_req) begin
                chk("sof_latency_valid", 32'(dn_if.valid), 32'd1);
                chk("sof_latency_data", 32'(dn_if.data), 32'(SOF_BYTE_DEFAULT));
            end
            if (trk > 0) begin
                trk++;
                if (trk == 3) begin
                    chk("trailer_latency", 32'(dn_if.valid && dn_if.last), 32'd1);
                    trk = 0;
                end
            end
            if (up_if.valid && up_if.ready && up_if.last) trk = 1;
            if (crc_clr) clr_seen = 1;
            if (crc_en) en_cnt++;
            if (dn_if.valid && dn_if.ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", 32'(dn_if.data), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", 32'(dn_if.data), 32'(e.d));
                    chk("out_last", 32'(dn_if.last), 32'(e.l));
                    if (e.f) begin
                        chk("clr_before_sof", 32'(clr_seen), 32'd1);
                        clr_seen = 0;
                    end
                    if (e.l) begin
                        int n;
                        n = elen_q.pop_front();
                        chk("crc_en_pulses", 32'(en_cnt), 32'(n));
                        last_en_cnt  = en_cnt;
                        en_cnt       = 0;
                        last_trailer = dn_if.data;
                        m_pl = n % 256;
                        m_fc = (m_fc + 1) % 65536;
                        xfer_idx = 0;
                    end else begin
                        xfer_idx++;
                    end
                end
            end
            prev_vld      = dn_if.valid;
            prev_rdy      = dn_if.ready;
            prev_dat      = dn_if.data;
            prev_last     = dn_if.last;
            prev_idle_req = !busy && up_if.valid;
        end
    end

    // Downstream ready: always, random, or scripted 2-cycle stalls on SOF, payload byte 2 and trailer.
    initial begin
        int stall, last_idx;
        stall = 0; last_idx = -1;
        dn_if.ready = 1'b1;
        forever begin
            @(posedge ck);
            #2;
            case (rdy_mode)
                1: dn_if.ready = ($urandom_range(0, 9) < 7);
                2: begin
                    if (xfer_idx != last_idx) begin
                        stall = 0;
                        last_idx = xfer_idx;
                    end
                    if (dn_if.valid && (xfer_idx == 0 || xfer_idx == 2 || xfer_idx == 4) && stall < 2) begin
                        dn_if.ready = 1'b0;
                        stall++;
                    end else begin
                        dn_if.ready = 1'b1;
                    end
                end
                default: dn_if.ready = 1'b1;
            endcase
        end
    end

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    task automatic drive_frame(input bit hold, input int abort_at);
        int n;
        n = fb.size();
        exp_q.push_back('{SOF_BYTE_DEFAULT, 1'b0, 1'b1});
        for (int i = 0; i < n; i++) exp_q.push_back('{fb[i], 1'b0, 1'b0});
        exp_q.push_back('{{3'b000, model_crc(fb)}, 1'b1, 1'b0});
        elen_q.push_back(n);
        exp_frames++;
        for (int i = 0; i < n; i++) begin
            bit x;
            int t;
            if (i == abort_at) begin
                up_if.valid = 1'b0;
                up_if.last  = 1'b0;
                return;
            end
            up_if.valid = 1'b1;
            up_if.data  = fb[i];
            up_if.last  = (i == n - 1);
            x = 0; t = 0;
            while (!x && t < 3000) begin
                @(negedge ck);
                x = up_if.ready;
                step();
                t++;
            end
            if (!x) begin
                n_cmp++; n_fail++;
                $display("FAIL in_xfer_timeout: byte %0d never accepted", i);
                up_if.valid = 1'b0;
                return;
            end
        end
        if (!hold) begin
            up_if.valid = 1'b0;
            up_if.last  = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge ck);
        while ((exp_q.size() != 0 || busy) && t < 5000) begin
            @(negedge ck);
            t++;
        end
        if (t >= 5000) begin
            n_cmp++; n_fail++;
            $display("FAIL frame_done_timeout: %0d bytes outstanding", exp_q.size());
        end
    endtask

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation did not finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1);
    end

    initial begin
        rdy_mode = 0;
        exp_frames = 0;
        rst = 1'b1;
        up_if.valid = 1'b0;
        up_if.data  = 8'h00;
        up_if.last  = 1'b0;
        repeat (3) @(posedge ck);
        #1;
        rst = 1'b0;

        // Reset state.
        @(negedge ck);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_valid", 32'(dn_if.valid), 32'd0);
        chk("rst_in_ready", 32'(up_if.ready), 32'd0);
        chk("rst_crc_en", 32'(crc_en), 32'd0);
        chk("rst_crc_clr", 32'(crc_clr), 32'd1);
        chk("rst_payload_len", 32'(payload_len), 32'd0);
        chk("rst_frame_count", 32'(frame_count), 32'd0);

        // Pin the reference CRC against hand-computed values.
        tq.delete(); tq.push_back(8'h00);
        chk("model_crc_00", 32'(model_crc(tq)), 32'h0F);
        tq.delete(); tq.push_back(8'hFF);
        chk("model_crc_ff", 32'(model_crc(tq)), 32'h1B);
        step();

        // Single byte 00.
        fb.delete(); fb.push_back(8'h00);
        drive_frame(0, -1);
        wait_idle();
        chk("t1_trailer", 32'(last_trailer), 32'h0F);
        chk("t1_payload_len", 32'(payload_len), 32'd1);
        chk("t1_frame_count", 32'(frame_count), 32'd1);
        step();

        // Single byte FF.
        fb.delete(); fb.push_back(8'hFF);
        drive_frame(0, -1);
        wait_idle();
        chk("t2_trailer", 32'(last_trailer), 32'h1B);
        chk("t2_en_pulses", 32'(last_en_cnt), 32'd1);
        step();

        // Three bytes with scripted stalls.
        rdy_mode = 2;
        fb.delete();
        for (int i = 0; i < 3; i++) fb.push_back(8'($urandom_range(0, 255)));
        tq = fb;
        drive_frame(0, -1);
        wait_idle();
        chk("t3_trailer", 32'(last_trailer), 32'(model_crc(tq)));
        chk("t3_en_pulses", 32'(last_en_cnt), 32'd3);
        rdy_mode = 0;
        step();

        // Two frames back to back, in_valid held high across the gap.
        fb.delete(); fb.push_back(8'h12); fb.push_back(8'h34); fb.push_back(8'h56);
        drive_frame(1, -1);
        fb.delete(); fb.push_back(8'h00);
        drive_frame(0, -1);
        wait_idle();
        chk("t4_trailer2", 32'(last_trailer), 32'h0F);
        chk("t4_frame_count", 32'(frame_count), 32'(exp_frames));
        step();

        // Reset in the middle of a payload.
        fb.delete();
        for (int i = 0; i < 5; i++) fb.push_back(8'($urandom_range(0, 255)));
        drive_frame(0, 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_frames = 0;
        @(negedge ck);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_out_valid", 32'(dn_if.valid), 32'd0);
        chk("t5_payload_len", 32'(payload_len), 32'd0);
        chk("t5_frame_count", 32'(frame_count), 32'd0);
        step();
        fb.delete(); fb.push_back(8'h00);
        drive_frame(0, -1);
        wait_idle();
        chk("t5_trailer", 32'(last_trailer), 32'h0F);
        chk("t5_frame_count_after", 32'(frame_count), 32'd1);
        step();

        // 256-byte frame: length counter wraps to zero.
        fb.delete();
        for (int i = 0; i < 256; i++) fb.push_back(8'($urandom_range(0, 255)));
        tq = fb;
        drive_frame(0, -1);
        wait_idle();
        chk("t6_payload_len", 32'(payload_len), 32'd0);
        chk("t6_trailer", 32'(last_trailer), 32'(model_crc(tq)));
        step();

        // Random frames, random downstream ready, random gaps or held valid.
        rdy_mode = 1;
        for (int k = 0; k < 20; k++) begin
            bit hold;
            int n;
            n = $urandom_range(1, 40);
            fb.delete();
            for (int i = 0; i < n; i++) fb.push_back(8'($urandom_range(0, 255)));
            hold = (k < 19) && ($urandom_range(0, 1) == 1);
            drive_frame(hold, -1);
            if (!hold) repeat ($urandom_range(0, 3)) step();
        end
        wait_idle();
        chk("t7_frame_count", 32'(frame_count), 32'(exp_frames));
        rdy_mode = 0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/crc5_frame_tx.md
Name: crc5_frame_tx

Overview:
- Transmit-side framer that sits directly upstream of the byte-wide CRC-5 engine.
- Wraps each payload frame as SOF byte, payload bytes, then one CRC trailer byte.
- Drives the engine's data/enable/clear inputs and reads its 5-bit result back for the trailer.
- Output stream feeds the serializer; input stream comes from the packet buffer.

Parameters:
SOF_BYTE, 8'hA5, start-of-frame byte emitted before every payload
LEN_W, 8, width of payload byte counter (payload_len, max 2^LEN_W-1, wraps)
CNT_W, 16, width of frame counter

Ports:
ck  in  1  clock, all logic on posedge
rst  in  1  reset, synchronous, active-high
in_valid  in  1  upstream byte valid
in_data  in  8  upstream payload byte
in_last  in  1  marks final payload byte of frame
in_ready  out  1  upstream byte accepted when in_valid&in_ready
out_valid  out  1  downstream byte valid
out_data  out  8  downstream byte
out_last  out  1  high on trailer byte only
out_ready  in  1  downstream accepts when out_valid&out_ready
crc_data  out  8  byte to CRC engine data input
crc_en  out  1  CRC engine update strobe
crc_clr  out  1  CRC engine synchronous clear (engine loads 5'h1F)
crc_value  in  5  CRC engine register output
payload_len  out  LEN_W  payload byte count of last completed frame
frame_count  out  CNT_W  completed frames since reset, wraps
busy  out  1  high in any state except IDLE

Behaviour:
- Engine contract: crc_en/crc_clr sampled at posedge; crc_value reflects the update the cycle after the strobe; init value 5'h1F.
- Reset: state=IDLE; payload_len=0, frame_count=0, internal len counter=0; out_valid=0, in_ready=0, crc_en=0; crc_clr=1 (IDLE value).
- FSM states: IDLE, SOF, PAYLOAD, CRC_WAIT, TRAILER.
- IDLE: crc_clr=1, in_ready=0, out_valid=0, len counter cleared. in_valid=1 -> SOF; the byte is not consumed.
- SOF: out_valid=1, out_data=SOF_BYTE, out_last=0, crc_clr=0, in_ready=0. out_ready -> PAYLOAD; otherwise hold with data stable. SOF is not included in the CRC.
- PAYLOAD is a combinational pass-through: out_valid=in_valid, out_data=in_data, in_ready=out_ready, out_last=0.
  - crc_data=in_data; crc_en=in_valid&out_ready (exactly one strobe per transferred byte).
  - Each transfer increments the len counter, which wraps at 2^LEN_W.
  - A transfer with in_last=1 -> CRC_WAIT.
- CRC_WAIT: exactly 1 cycle; outputs idle; lets the engine register the last byte -> TRAILER.
- TRAILER: out_valid=1, out_data={3'b000,crc_value}, out_last=1, in_ready=0. Hold stable until out_ready.
  - On transfer: payload_len<=len counter, frame_count<=frame_count+1 (wrap) -> IDLE.
- Latency: out_valid asserts 1 cycle after in_valid first rises in IDLE; trailer is valid 2 cycles after the last payload transfer.
- Back-to-back frames: at least 1 IDLE cycle between trailer and next SOF. This guarantees a crc_clr cycle.
- crc_en is never high outside PAYLOAD; crc_clr is high only in IDLE.
- Backpressure: out_data and out_last must not change while out_valid=1 and out_ready=0.
- rst mid-frame: return to IDLE next edge; partial frame dropped; counters zeroed; engine cleared via crc_clr.
- Upstream must not deassert in_valid with a byte pending. This is not checked; add an SVA assumption in the bench.

Decomposition:
- Shared package: FSM state enum (3-bit) and default SOF constant 8'hA5.
- No sub-module; the CRC engine is instantiated beside this block at the next level up.
- The bench instantiates both blocks together.

Test Plan:
- Single byte 8'h00, in_last=1, out_ready=1 -> out stream A5,00,0F; out_last on 0F; payload_len=1, frame_count=1.
- Single byte 8'hFF -> stream A5,FF,1B; crc_en high exactly 1 cycle.
- 3-byte frame with out_ready low for 2 cycles during SOF, payload byte 2 and trailer -> data held stable; in_ready=0 while stalled; exactly 3 crc_en pulses; trailer matches a software CRC-5 model (init 1F).
- Two frames back-to-back with in_valid held high -> crc_clr high ≥1 cycle between frames; second trailer independent of first; frame_count=2.
- rst asserted 1 cycle while in PAYLOAD after 2 bytes -> next cycle IDLE, busy=0, out_valid=0, counters 0; next frame 8'h00 yields trailer 0F.
- 256-byte frame with LEN_W=8 -> payload_len wraps to 0; trailer matches model.
